// File: rtl/demux_rr_fifo_if.sv
// Bus between the round-robin demux and its environment: the incoming
// stream, the per-lane pop requests, the read data and the lane status flags.
interface demux_rr_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  pop_0;
  logic                  pop_1;
  logic [DATA_WIDTH-1:0] data_out_0;
  logic [DATA_WIDTH-1:0] data_out_1;
  logic                  valid_out_0;
  logic                  valid_out_1;
  logic                  empty_0;
  logic                  empty_1;
  logic                  full_0;
  logic                  full_1;
  logic                  almost_full_0;
  logic                  almost_full_1;
  logic                  overflow_0;
  logic                  overflow_1;
  logic                  underflow_0;
  logic                  underflow_1;

  modport master (
    output data_in, valid_in, pop_0, pop_1,
    input  data_out_0, data_out_1, valid_out_0, valid_out_1,
    input  empty_0, empty_1, full_0, full_1,
    input  almost_full_0, almost_full_1,
    input  overflow_0, overflow_1, underflow_0, underflow_1
  );

  modport slave (
    input  data_in, valid_in, pop_0, pop_1,
    output data_out_0, data_out_1, valid_out_0, valid_out_1,
    output empty_0, empty_1, full_0, full_1,
    output almost_full_0, almost_full_1,
    output overflow_0, overflow_1, underflow_0, underflow_1
  );
endinterface

// File: rtl/demux_rr_fifo.sv
// 1-to-2 round-robin demultiplexer with a small FIFO per lane, registered
// read data and sticky overflow/underflow flags.
module demux_rr_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = 3
) (
  input  logic            clk,
  input  logic            reset_L,
  demux_rr_fifo_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_r      [2][DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r   [2];
  logic [PTR_W-1:0]      rd_ptr_r   [2];
  logic [CNT_W-1:0]      count_r    [2];
  logic [DATA_WIDTH-1:0] data_out_r [2];
  logic [1:0]            valid_out_r;
  logic [1:0]            overflow_r;
  logic [1:0]            underflow_r;
  logic                  sel_r;

  logic [1:0] target_s;
  logic [1:0] pop_s;
  logic [1:0] empty_s;
  logic [1:0] full_s;
  logic [1:0] af_s;
  logic [1:0] wr_en_s;
  logic [1:0] rd_en_s;

  // Lane status and per-lane write/read qualification, judged on cycle-start count.
  always_comb begin
    target_s = 2'b00;
    pop_s    = {bus.pop_1, bus.pop_0};
    empty_s  = 2'b00;
    full_s   = 2'b00;
    af_s     = 2'b00;
    wr_en_s  = 2'b00;
    rd_en_s  = 2'b00;
    if (bus.valid_in) begin
      target_s = sel_r ? 2'b10 : 2'b01;
    end else begin
      target_s = 2'b00;
    end
    for (int l = 0; l < 2; l++) begin
      empty_s[l] = (count_r[l] == CNT_W'(0));
      full_s[l]  = (count_r[l] == CNT_W'(DEPTH));
      af_s[l]    = (count_r[l] >= CNT_W'(AF_LEVEL));
      wr_en_s[l] = target_s[l] & ~full_s[l];
      rd_en_s[l] = pop_s[l] & ~empty_s[l];
    end
  end

  // Lane storage; contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (wr_en_s[l]) begin
        mem_r[l][wr_ptr_r[l]] <= bus.data_in;
      end
    end
  end

  // Round-robin selector: advances on every valid word, stored or dropped.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_r <= 1'b0;
    end else if (bus.valid_in) begin
      sel_r <= ~sel_r;
    end
  end

  // Pointers, counts, registered read port and sticky error flags per lane.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr_r[l]   <= PTR_W'(0);
        rd_ptr_r[l]   <= PTR_W'(0);
        count_r[l]    <= CNT_W'(0);
        data_out_r[l] <= DATA_WIDTH'(0);
      end
      valid_out_r <= 2'b00;
      overflow_r  <= 2'b00;
      underflow_r <= 2'b00;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (wr_en_s[l]) begin
          wr_ptr_r[l] <= wr_ptr_r[l] + PTR_W'(1);
        end
        if (rd_en_s[l]) begin
          rd_ptr_r[l]   <= rd_ptr_r[l] + PTR_W'(1);
          data_out_r[l] <= mem_r[l][rd_ptr_r[l]];
        end
        case ({wr_en_s[l], rd_en_s[l]})
          2'b10:   count_r[l] <= count_r[l] + CNT_W'(1);
          2'b01:   count_r[l] <= count_r[l] - CNT_W'(1);
          default: count_r[l] <= count_r[l];
        endcase
        valid_out_r[l] <= rd_en_s[l];
        if (target_s[l] && full_s[l]) begin
          overflow_r[l] <= 1'b1;
        end
        if (pop_s[l] && empty_s[l]) begin
          underflow_r[l] <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out_0    = data_out_r[0];
  assign bus.data_out_1    = data_out_r[1];
  assign bus.valid_out_0   = valid_out_r[0];
  assign bus.valid_out_1   = valid_out_r[1];
  assign bus.empty_0       = empty_s[0];
  assign bus.empty_1       = empty_s[1];
  assign bus.full_0        = full_s[0];
  assign bus.full_1        = full_s[1];
  assign bus.almost_full_0 = af_s[0];
  assign bus.almost_full_1 = af_s[1];
  assign bus.overflow_0    = overflow_r[0];
  assign bus.overflow_1    = overflow_r[1];
  assign bus.underflow_0   = underflow_r[0];
  assign bus.underflow_1   = underflow_r[1];
endmodule

// File: tb/tb_demux_rr_fifo.sv
// Directed bench for demux_rr_fifo: routing, per-lane FIFO order, full/empty
// boundaries, sticky error flags and asynchronous reset.
module tb_demux_rr_fifo;
  logic clk;
  logic reset_L;
  int   checks_cnt;
  int   fail_cnt;

  demux_rr_fifo_if #(.DATA_WIDTH(8)) bus ();

  demux_rr_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic p0, input logic p1);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.pop_0    = p0;
    bus.pop_1    = p1;
  endtask

  // One clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"},  {30'd0, bus.empty_1, bus.empty_0}, 32'h3);
    check({tag, "_full"},   {30'd0, bus.full_1, bus.full_0}, 32'h0);
    check({tag, "_af"},     {30'd0, bus.almost_full_1, bus.almost_full_0}, 32'h0);
    check({tag, "_vout"},   {30'd0, bus.valid_out_1, bus.valid_out_0}, 32'h0);
    check({tag, "_dout"},   {16'd0, bus.data_out_1, bus.data_out_0}, 32'h0);
    check({tag, "_ovf"},    {30'd0, bus.overflow_1, bus.overflow_0}, 32'h0);
    check({tag, "_udf"},    {30'd0, bus.underflow_1, bus.underflow_0}, 32'h0);
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    reset_L    = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #22;
    check_reset_state("rst");
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;

    // A0..A3 alternate lanes starting at lane 0.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("fill4_empty", {30'd0, bus.empty_1, bus.empty_0}, 32'h0);
    check("fill4_af",    {30'd0, bus.almost_full_1, bus.almost_full_0}, 32'h0);

    drive(1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    check("pop_a_v0", {31'd0, bus.valid_out_0}, 32'h1);
    check("pop_a_d0", {24'd0, bus.data_out_0}, 32'hA0);
    check("pop_a_d1", {24'd0, bus.data_out_1}, 32'hA1);
    tick();
    check("pop_b_d0", {24'd0, bus.data_out_0}, 32'hA2);
    check("pop_b_d1", {24'd0, bus.data_out_1}, 32'hA3);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check("idle_v",     {30'd0, bus.valid_out_1, bus.valid_out_0}, 32'h0);
    check("idle_hold0", {24'd0, bus.data_out_0}, 32'hA2);
    check("drain_empty", {30'd0, bus.empty_1, bus.empty_0}, 32'h3);
    check("drain_udf",   {30'd0, bus.underflow_1, bus.underflow_0}, 32'h0);

    // Ten words: 0x18 and 0x19 hit full lanes and are dropped.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_full", {30'd0, bus.full_1, bus.full_0}, 32'h3);
    check("ovf_af",   {30'd0, bus.almost_full_1, bus.almost_full_0}, 32'h3);
    check("ovf_flag", {30'd0, bus.overflow_1, bus.overflow_0}, 32'h3);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ovf_order0", {23'd0, bus.valid_out_0, bus.data_out_0}, 32'h110 + 32'(2 * i));
      check("ovf_order1", {23'd0, bus.valid_out_1, bus.data_out_1}, 32'h111 + 32'(2 * i));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_drained", {30'd0, bus.empty_1, bus.empty_0}, 32'h3);

    // Underflow on an empty lane; data holds, flag is sticky.
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    check("udf1_flag", {30'd0, bus.underflow_1, bus.underflow_0}, 32'h2);
    check("udf1_v",    {31'd0, bus.valid_out_1}, 32'h0);
    check("udf1_hold", {24'd0, bus.data_out_1}, 32'h17);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check("udf_sticky", {30'd0, bus.underflow_1, bus.underflow_0}, 32'h3);
    check("udf0_hold",  {24'd0, bus.data_out_0}, 32'h16);

    // sel must be back at lane 0 after an even count of valid words.
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    tick();
    check("sel_lane0", {30'd0, bus.empty_1, bus.empty_0}, 32'h2);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h56 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("cnt3_af",   {30'd0, bus.almost_full_1, bus.almost_full_0}, 32'h3);
    check("cnt3_full", {30'd0, bus.full_1, bus.full_0}, 32'h0);

    // Lane 0 at count 3: simultaneous write and pop leaves count at 3.
    drive(1'b1, 8'h5B, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("wr_rd_d0",   {23'd0, bus.valid_out_0, bus.data_out_0}, 32'h155);
    check("wr_rd_af",   {31'd0, bus.almost_full_0}, 32'h1);
    check("wr_rd_full", {31'd0, bus.full_0}, 32'h0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check("wr_rd_o1", {24'd0, bus.data_out_0}, 32'h57);
    tick();
    check("wr_rd_o2", {24'd0, bus.data_out_0}, 32'h59);
    tick();
    check("wr_rd_o3", {24'd0, bus.data_out_0}, 32'h5B);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("wr_rd_empty", {31'd0, bus.empty_0}, 32'h1);

    // Mid-burst async reset between edges; lane 1 is the current target.
    drive(1'b1, 8'h60, 1'b0, 1'b1);
    tick();
    check("pre_rst_d1", {23'd0, bus.valid_out_1, bus.data_out_1}, 32'h156);
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    #2;
    reset_L = 1'b0;
    #1;
    check_reset_state("arst");
    @(negedge clk);
    reset_L = 1'b1;
    drive(1'b1, 8'h70, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_lane", {30'd0, bus.empty_1, bus.empty_0}, 32'h2);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_d0", {23'd0, bus.valid_out_0, bus.data_out_0}, 32'h170);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/demux_rr_fifo.md
Name: demux_rr_fifo

Overview:
- 1-to-2 demultiplexer at the receive end of the two-lane serialised byte stream.
- Takes one 8-bit valid-qualified stream and splits it back into lane 0 and lane 1 in strict round-robin order; the first word after reset goes to lane 0.
- Each lane has a small FIFO so that downstream consumers can drain it at their own pace using pop requests.
- Overflow and underflow are flagged and held per lane.

Parameters:
- DATA_WIDTH, 8, width of data words.
- DEPTH, 4, entries per lane FIFO; power of two, minimum 2.
- AF_LEVEL, 3, almost-full threshold; almost_full_x asserts when the lane count is at or above this value.

Ports:
- clk  input  1  single clock, rising edge.
- reset_L  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  incoming word.
- valid_in  input  1  data_in is valid this cycle.
- pop_0  input  1  read request, lane 0.
- pop_1  input  1  read request, lane 1.
- data_out_0  output  DATA_WIDTH  registered read data, lane 0.
- data_out_1  output  DATA_WIDTH  registered read data, lane 1.
- valid_out_0  output  1  data_out_0 is valid this cycle.
- valid_out_1  output  1  data_out_1 is valid this cycle.
- empty_0, empty_1  output  1  lane FIFO empty.
- full_0, full_1  output  1  lane FIFO full.
- almost_full_0, almost_full_1  output  1  lane count >= AF_LEVEL.
- overflow_0, overflow_1  output  1  sticky: a word was dropped on this lane.
- underflow_0, underflow_1  output  1  sticky: a pop was issued while the lane was empty.

Behaviour:
- Reset (asynchronous, reset_L low):
  - All pointers, counts and the lane selector (sel) are cleared to 0.
  - data_out_x = 0, valid_out_x = 0, overflow_x = 0, underflow_x = 0.
  - empty_x = 1, full_x = 0, almost_full_x = 0.
  - FIFO storage contents are don't-care.
  - A reset asserted mid-stream discards all buffered words; the first valid word after release goes to lane 0.
- Routing:
  - On each rising edge with valid_in = 1, the word targets lane sel.
  - sel toggles on every valid_in cycle, whether or not the word is stored. This keeps lane alignment with the sender.
  - sel is unchanged when valid_in = 0.
- Write:
  - If the target lane is not full at the start of the cycle, the word is written at wr_ptr, wr_ptr increments modulo DEPTH and count increments.
  - If the target lane is full, the word is dropped and overflow_x is set. A pop on the same lane in the same cycle does not rescue the word; fullness is judged at cycle start.
- Read:
  - pop_x = 1 with the lane not empty at cycle start: on the next edge data_out_x <= mem[rd_ptr], valid_out_x <= 1, rd_ptr increments modulo DEPTH and count decrements. Latency is 1 cycle from pop to valid_out.
  - pop_x = 1 with the lane empty: underflow_x is set, valid_out_x <= 0, data_out_x holds its previous value.
  - pop_x = 0: valid_out_x <= 0, data_out_x holds its previous value.
- Simultaneous write and read on the same lane:
  - Not full and not empty: both occur and count is unchanged.
  - Empty lane with write and pop: the write is stored and the pop counts as an underflow. There is no fall-through.
- Flags:
  - empty_x, full_x and almost_full_x are combinational from the registered count.
  - overflow_x and underflow_x are cleared only by reset.
- Lane independence: the two lanes are fully independent apart from the shared sel.
- Wrap-around: pointer wrap-around is transparent; ordering within a lane is strictly FIFO.

Test Plan:
- Reset, then valid_in = 1 for 4 cycles with data 0xA0, 0xA1, 0xA2, 0xA3 and no pops -> lane 0 holds A0, A2; lane 1 holds A1, A3; count 2 on each lane, empty_x = 0.
- Pop lane 0 on 2 consecutive cycles -> data_out_0 = 0xA0 then 0xA1... no: data_out_0 = 0xA0 then 0xA2, with valid_out_0 high 1 cycle after each pop; empty_0 = 1 afterwards.
- Send 10 words (0x10–0x19) with no pops -> each lane holds 4 words; words 0x18 and 0x19 are dropped; overflow_0 = overflow_1 = 1; sel = 0 afterwards.
- Pop with the lane empty -> underflow_x = 1 and valid_out_x = 0; the flag stays set until reset.
- With lane 0 at count 3, push to lane 0 while popping lane 0 -> count stays 3, almost_full_0 = 1, ordering preserved.
- Assert reset_L low asynchronously mid-burst (no clock edge) -> outputs reset immediately; after release, the next valid word lands in lane 0.
